// File: rtl/control_pkg.sv
// Shared encodings for the control sequencer: states, opcodes, function-select codes,
// the decoded instruction classes and the packed control word driven to the datapath.
package control_pkg;

    // State encoding follows declaration order; it is visible on the State debug port.
    typedef enum logic [2:0] {
        ST_FETCH_L = 3'd0,
        ST_FETCH_H = 3'd1,
        ST_EXEC    = 3'd2,
        ST_EXEC2   = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    localparam logic [5:0] OP_BRA = 6'h00;
    localparam logic [5:0] OP_BNE = 6'h01;
    localparam logic [5:0] OP_BEQ = 6'h02;
    localparam logic [5:0] OP_LDR = 6'h10;
    localparam logic [5:0] OP_STR = 6'h11;
    localparam logic [5:0] OP_IMM = 6'h12;
    localparam logic [5:0] OP_ADD = 6'h15;
    localparam logic [5:0] OP_SUB = 6'h16;
    localparam logic [5:0] OP_AND = 6'h17;
    localparam logic [5:0] OP_ORR = 6'h18;
    localparam logic [5:0] OP_HLT = 6'h3F;

    localparam logic [2:0] FUN_LOAD = 3'b010;
    localparam logic [2:0] FUN_INC  = 3'b001;

    localparam logic [4:0] ALU_PASS_A = 5'b10000;
    localparam logic [4:0] ALU_ADD    = 5'b10100;
    localparam logic [4:0] ALU_SUB    = 5'b10110;
    localparam logic [4:0] ALU_AND    = 5'b10111;
    localparam logic [4:0] ALU_ORR    = 5'b11000;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_BRANCH,
        CLS_LDR,
        CLS_STR,
        CLS_IMM,
        CLS_ALU,
        CLS_HLT
    } op_class_t;

    typedef struct packed {
        logic [2:0] rf_outa;
        logic [2:0] rf_outb;
        logic [2:0] rf_fun;
        logic [3:0] rf_reg;
        logic [3:0] rf_scr;
        logic [4:0] alu_fun;
        logic       alu_wf;
        logic [1:0] arf_outc;
        logic [1:0] arf_outd;
        logic [2:0] arf_fun;
        logic [2:0] arf_reg;
        logic       ir_lh;
        logic       ir_write;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a;
        logic [1:0] mux_b;
        logic       mux_c;
    } ctrl_t;

    // Register select bit3 is R1, so R1 (code 00) maps to 4'b1000.
    function automatic logic [3:0] reg_onehot(input logic [1:0] sel);
        return 4'b1000 >> sel;
    endfunction

    function automatic ctrl_t idle_ctrl();
        ctrl_t c;
        c        = '0;
        c.mem_cs = 1'b1;
        return c;
    endfunction

    // Store spans two cycles; the second one only flips MuxCSel to the other data half.
    function automatic ctrl_t str_ctrl(input logic [1:0] rsel, input logic second);
        ctrl_t c;
        c          = idle_ctrl();
        c.rf_outa  = {1'b0, rsel};
        c.alu_fun  = ALU_PASS_A;
        c.mux_c    = second;
        c.arf_outd = 2'b10;
        c.mem_cs   = 1'b0;
        c.mem_wr   = 1'b1;
        c.arf_reg  = 3'b010;
        c.arf_fun  = FUN_INC;
        return c;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the instruction decoder and the sequencer: raw IR in, decoded class and fields out.
interface control_sequencer_if;
    import control_pkg::*;

    logic [15:0] ir;
    op_class_t   op_class;
    logic [4:0]  alu_fun;
    logic [1:0]  br_cond;
    logic [1:0]  rsel;
    logic [1:0]  dst;
    logic [1:0]  sreg1;
    logic [1:0]  sreg2;

    modport master (input ir, output op_class, alu_fun, br_cond, rsel, dst, sreg1, sreg2);
    modport slave  (output ir, input op_class, alu_fun, br_cond, rsel, dst, sreg1, sreg2);

endinterface

// File: rtl/instruction_decoder.sv
// Purely combinational split of the instruction register into a class plus register fields.
module instruction_decoder
    import control_pkg::*;
(
    control_sequencer_if.master dec
);

    logic [5:0] opcode;

    assign opcode = dec.ir[15:10];

    always_comb begin
        dec.op_class = CLS_NOP;
        dec.alu_fun  = '0;
        case (opcode)
            OP_BRA, OP_BNE, OP_BEQ: dec.op_class = CLS_BRANCH;
            OP_LDR: dec.op_class = CLS_LDR;
            OP_STR: dec.op_class = CLS_STR;
            OP_IMM: dec.op_class = CLS_IMM;
            OP_ADD: begin dec.op_class = CLS_ALU; dec.alu_fun = ALU_ADD; end
            OP_SUB: begin dec.op_class = CLS_ALU; dec.alu_fun = ALU_SUB; end
            OP_AND: begin dec.op_class = CLS_ALU; dec.alu_fun = ALU_AND; end
            OP_ORR: begin dec.op_class = CLS_ALU; dec.alu_fun = ALU_ORR; end
            OP_HLT: dec.op_class = CLS_HLT;
            default: dec.op_class = CLS_NOP;
        endcase
    end

    // Branch condition is the low opcode bits: 00 always, 01 on Z clear, 10 on Z set.
    assign dec.br_cond = opcode[1:0];
    assign dec.rsel    = dec.ir[9:8];
    assign dec.dst     = dec.ir[7:6];
    assign dec.sreg1   = dec.ir[4:3];
    assign dec.sreg2   = dec.ir[1:0];

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle controller: two-byte fetch, one execute cycle (two for stores), halt until reset.
module control_sequencer
    import control_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  Flags,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [2:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Write,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic [2:0]  State,
    output logic        Halted
);

    state_t state_q, state_d;
    ctrl_t  ctrl;
    logic   take_branch;

    control_sequencer_if dec_if ();

    assign dec_if.ir = IROut;

    instruction_decoder u_decoder (
        .dec (dec_if.master)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH_L: state_d = ST_FETCH_H;
            ST_FETCH_H: state_d = ST_EXEC;
            ST_EXEC: begin
                if (dec_if.op_class == CLS_STR)      state_d = ST_EXEC2;
                else if (dec_if.op_class == CLS_HLT) state_d = ST_HALT;
                else                                 state_d = ST_FETCH_L;
            end
            ST_EXEC2: state_d = ST_FETCH_L;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH_L;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) state_q <= ST_FETCH_L;
        else       state_q <= state_d;
    end

    always_comb begin
        ctrl        = idle_ctrl();
        take_branch = 1'b0;
        case (dec_if.br_cond)
            2'b00:   take_branch = 1'b1;
            2'b01:   take_branch = ~Flags[3];
            2'b10:   take_branch = Flags[3];
            default: take_branch = 1'b0;
        endcase
        case (state_q)
            ST_FETCH_L, ST_FETCH_H: begin
                ctrl.arf_outd = 2'b00;
                ctrl.mem_cs   = 1'b0;
                ctrl.ir_write = 1'b1;
                ctrl.ir_lh    = (state_q == ST_FETCH_H);
                ctrl.arf_reg  = 3'b100;
                ctrl.arf_fun  = FUN_INC;
            end
            ST_EXEC: begin
                case (dec_if.op_class)
                    CLS_BRANCH: begin
                        ctrl.mux_b   = 2'b11;
                        ctrl.arf_fun = FUN_LOAD;
                        ctrl.arf_reg = take_branch ? 3'b100 : 3'b000;
                    end
                    CLS_LDR: begin
                        ctrl.arf_outd = 2'b10;
                        ctrl.mem_cs   = 1'b0;
                        ctrl.mux_a    = 2'b10;
                        ctrl.rf_fun   = FUN_LOAD;
                        ctrl.rf_reg   = reg_onehot(dec_if.rsel);
                    end
                    CLS_STR: ctrl = str_ctrl(dec_if.rsel, 1'b0);
                    CLS_IMM: begin
                        ctrl.mux_a  = 2'b11;
                        ctrl.rf_fun = FUN_LOAD;
                        ctrl.rf_reg = reg_onehot(dec_if.rsel);
                    end
                    CLS_ALU: begin
                        ctrl.rf_outa = {1'b0, dec_if.sreg1};
                        ctrl.rf_outb = {1'b0, dec_if.sreg2};
                        ctrl.alu_fun = dec_if.alu_fun;
                        ctrl.alu_wf  = 1'b1;
                        ctrl.mux_a   = 2'b00;
                        ctrl.rf_fun  = FUN_LOAD;
                        ctrl.rf_reg  = reg_onehot(dec_if.dst);
                    end
                    default: ctrl = idle_ctrl();
                endcase
            end
            ST_EXEC2: ctrl = str_ctrl(dec_if.rsel, 1'b1);
            default:  ctrl = idle_ctrl();
        endcase
        // Reset blanks the control word immediately so an in-flight store never completes.
        if (Reset) ctrl = idle_ctrl();
    end

    assign RF_OutASel  = ctrl.rf_outa;
    assign RF_OutBSel  = ctrl.rf_outb;
    assign RF_FunSel   = ctrl.rf_fun;
    assign RF_RegSel   = ctrl.rf_reg;
    assign RF_ScrSel   = ctrl.rf_scr;
    assign ALU_FunSel  = ctrl.alu_fun;
    assign ALU_WF      = ctrl.alu_wf;
    assign ARF_OutCSel = ctrl.arf_outc;
    assign ARF_OutDSel = ctrl.arf_outd;
    assign ARF_FunSel  = ctrl.arf_fun;
    assign ARF_RegSel  = ctrl.arf_reg;
    assign IR_LH       = ctrl.ir_lh;
    assign IR_Write    = ctrl.ir_write;
    assign Mem_WR      = ctrl.mem_wr;
    assign Mem_CS      = ctrl.mem_cs;
    assign MuxASel     = ctrl.mux_a;
    assign MuxBSel     = ctrl.mux_b;
    assign MuxCSel     = ctrl.mux_c;
    assign State       = state_q;
    assign Halted      = (state_q == ST_HALT) && !Reset;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed table, hand-written corner sequences,
// then random instruction streams compared against a cycle-step reference model.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [3:0]  Flags;
    logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel;
    logic [2:0]  ARF_FunSel, ARF_RegSel;
    logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel;
    logic [2:0]  State;
    logic        Halted;

    control_sequencer_if dec_bus ();

    control_sequencer dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .IROut       (dec_bus.ir),
        .Flags       (Flags),
        .RF_OutASel  (RF_OutASel),
        .RF_OutBSel  (RF_OutBSel),
        .RF_FunSel   (RF_FunSel),
        .RF_RegSel   (RF_RegSel),
        .RF_ScrSel   (RF_ScrSel),
        .ALU_FunSel  (ALU_FunSel),
        .ALU_WF      (ALU_WF),
        .ARF_OutCSel (ARF_OutCSel),
        .ARF_OutDSel (ARF_OutDSel),
        .ARF_FunSel  (ARF_FunSel),
        .ARF_RegSel  (ARF_RegSel),
        .IR_LH       (IR_LH),
        .IR_Write    (IR_Write),
        .Mem_WR      (Mem_WR),
        .Mem_CS      (Mem_CS),
        .MuxASel     (MuxASel),
        .MuxBSel     (MuxBSel),
        .MuxCSel     (MuxCSel),
        .State       (State),
        .Halted      (Halted)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [2:0] rf_outa, rf_outb, rf_fun;
        logic [3:0] rf_reg, rf_scr;
        logic [4:0] alu_fun;
        logic       alu_wf;
        logic [1:0] arf_outc, arf_outd;
        logic [2:0] arf_fun, arf_reg;
        logic       ir_lh, ir_write, mem_wr, mem_cs;
        logic [1:0] mux_a, mux_b;
        logic       mux_c;
        logic [2:0] state;
        logic       halted;
    } obs_t;

    typedef struct {
        logic [15:0] ir;
        logic [3:0]  flags;
        logic [2:0]  rf_outa, rf_outb, rf_fun;
        logic [3:0]  rf_reg;
        logic [4:0]  alu_fun;
        logic        alu_wf;
        logic [2:0]  arf_fun, arf_reg;
        logic [1:0]  mux_a, mux_b;
        logic        mem_wr, mem_cs;
        logic [2:0]  next;
    } vec_t;

    int checks_total = 0;
    int checks_passed = 0;

    // Reference model: position inside the current instruction and halt status.
    int m_step   = 0;
    bit m_halted = 1'b0;
    bit m_valid  = 1'b0;

    vec_t vecs[14];
    logic [5:0] op_pool[12];
    logic [7:0] mem[2];

    function automatic logic [3:0] onehot_ref(input logic [1:0] sel);
        return 4'(1 << (3 - int'(sel)));
    endfunction

    function automatic obs_t model_out(input int step, input bit halted, input logic [15:0] ir,
                                       input logic [3:0] fl, input logic rst);
        obs_t       o;
        logic [5:0] op;
        o        = '0;
        o.mem_cs = 1'b1;
        o.state  = halted ? 3'd4 : 3'(step);
        if (rst) return o;
        if (halted) begin
            o.halted = 1'b1;
            return o;
        end
        op = ir[15:10];
        if (step < 2) begin
            o.mem_cs   = 1'b0;
            o.ir_write = 1'b1;
            o.ir_lh    = (step == 1);
            o.arf_reg  = 3'b100;
            o.arf_fun  = 3'b001;
        end else if (step == 3 || op == 6'h11) begin
            o.rf_outa  = {1'b0, ir[9:8]};
            o.alu_fun  = 5'b10000;
            o.mux_c    = (step == 3);
            o.arf_outd = 2'b10;
            o.mem_cs   = 1'b0;
            o.mem_wr   = 1'b1;
            o.arf_reg  = 3'b010;
            o.arf_fun  = 3'b001;
        end else begin
            case (op)
                6'h00, 6'h01, 6'h02: begin
                    o.mux_b   = 2'b11;
                    o.arf_fun = 3'b010;
                    if (op == 6'h00 || (op == 6'h01 && !fl[3]) || (op == 6'h02 && fl[3]))
                        o.arf_reg = 3'b100;
                end
                6'h10: begin
                    o.arf_outd = 2'b10;
                    o.mem_cs   = 1'b0;
                    o.mux_a    = 2'b10;
                    o.rf_fun   = 3'b010;
                    o.rf_reg   = onehot_ref(ir[9:8]);
                end
                6'h12: begin
                    o.mux_a  = 2'b11;
                    o.rf_fun = 3'b010;
                    o.rf_reg = onehot_ref(ir[9:8]);
                end
                6'h15, 6'h16, 6'h17, 6'h18: begin
                    o.rf_outa = {1'b0, ir[4:3]};
                    o.rf_outb = {1'b0, ir[1:0]};
                    o.alu_fun = (op == 6'h15) ? 5'b10100 : (op == 6'h16) ? 5'b10110 :
                                (op == 6'h17) ? 5'b10111 : 5'b11000;
                    o.alu_wf  = 1'b1;
                    o.rf_fun  = 3'b010;
                    o.rf_reg  = onehot_ref(ir[7:6]);
                end
                default: ;
            endcase
        end
        return o;
    endfunction

    function automatic void model_advance(input logic rst, input logic [15:0] ir);
        if (rst) begin
            m_step   = 0;
            m_halted = 1'b0;
            m_valid  = 1'b1;
        end else if (m_valid && !m_halted) begin
            case (m_step)
                0: m_step = 1;
                1: m_step = 2;
                2: begin
                    if (ir[15:10] == 6'h11)      m_step = 3;
                    else if (ir[15:10] == 6'h3F) m_halted = 1'b1;
                    else                         m_step = 0;
                end
                default: m_step = 0;
            endcase
        end
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.rf_outa = RF_OutASel;   o.rf_outb = RF_OutBSel;   o.rf_fun = RF_FunSel;
        o.rf_reg = RF_RegSel;     o.rf_scr = RF_ScrSel;     o.alu_fun = ALU_FunSel;
        o.alu_wf = ALU_WF;        o.arf_outc = ARF_OutCSel; o.arf_outd = ARF_OutDSel;
        o.arf_fun = ARF_FunSel;   o.arf_reg = ARF_RegSel;   o.ir_lh = IR_LH;
        o.ir_write = IR_Write;    o.mem_wr = Mem_WR;        o.mem_cs = Mem_CS;
        o.mux_a = MuxASel;        o.mux_b = MuxBSel;        o.mux_c = MuxCSel;
        o.state = State;          o.halted = Halted;
        return o;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One clock cycle from the low phase: compare against the model, clock, advance the model.
    task automatic apply_stimulus(input logic rst, input string name);
        obs_t exp_o, act_o;
        Reset = rst;
        #1;
        exp_o = model_out(m_step, m_halted, dec_bus.ir, Flags, rst);
        act_o = observe();
        if (!m_valid) begin
            exp_o.state = 3'd0;
            act_o.state = 3'd0;
        end
        check_output(name, 64'(act_o), 64'(exp_o));
        @(posedge Clock);
        model_advance(rst, dec_bus.ir);
        @(negedge Clock);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs[0]  = '{16'h4905, 4'h0, 3'd0, 3'd0, 3'b010, 4'b0100, 5'b00000, 1'b0, 3'b000, 3'b000, 2'b11, 2'b00, 1'b0, 1'b1, 3'd0};
        vecs[1]  = '{16'h55A5, 4'h0, 3'd0, 3'd1, 3'b010, 4'b0010, 5'b10100, 1'b1, 3'b000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1, 3'd0};
        vecs[2]  = '{16'h0820, 4'h8, 3'd0, 3'd0, 3'b000, 4'b0000, 5'b00000, 1'b0, 3'b010, 3'b100, 2'b00, 2'b11, 1'b0, 1'b1, 3'd0};
        vecs[3]  = '{16'h0820, 4'h0, 3'd0, 3'd0, 3'b000, 4'b0000, 5'b00000, 1'b0, 3'b010, 3'b000, 2'b00, 2'b11, 1'b0, 1'b1, 3'd0};
        vecs[4]  = '{16'h0400, 4'h0, 3'd0, 3'd0, 3'b000, 4'b0000, 5'b00000, 1'b0, 3'b010, 3'b100, 2'b00, 2'b11, 1'b0, 1'b1, 3'd0};
        vecs[5]  = '{16'h0400, 4'h8, 3'd0, 3'd0, 3'b000, 4'b0000, 5'b00000, 1'b0, 3'b010, 3'b000, 2'b00, 2'b11, 1'b0, 1'b1, 3'd0};
        vecs[6]  = '{16'h0000, 4'h8, 3'd0, 3'd0, 3'b000, 4'b0000, 5'b00000, 1'b0, 3'b010, 3'b100, 2'b00, 2'b11, 1'b0, 1'b1, 3'd0};
        vecs[7]  = '{16'h4200, 4'h0, 3'd0, 3'd0, 3'b010, 4'b0010, 5'b00000, 1'b0, 3'b000, 3'b000, 2'b10, 2'b00, 1'b0, 1'b0, 3'd0};
        vecs[8]  = '{16'h4700, 4'h0, 3'd3, 3'd0, 3'b000, 4'b0000, 5'b10000, 1'b0, 3'b001, 3'b010, 2'b00, 2'b00, 1'b1, 1'b0, 3'd3};
        vecs[9]  = '{16'h5800, 4'h0, 3'd0, 3'd0, 3'b010, 4'b1000, 5'b10110, 1'b1, 3'b000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1, 3'd0};
        vecs[10] = '{16'h5CD3, 4'h0, 3'd2, 3'd3, 3'b010, 4'b0001, 5'b10111, 1'b1, 3'b000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1, 3'd0};
        vecs[11] = '{16'h61C0, 4'h0, 3'd0, 3'd0, 3'b010, 4'b0001, 5'b11000, 1'b1, 3'b000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1, 3'd0};
        vecs[12] = '{16'h2000, 4'h0, 3'd0, 3'd0, 3'b000, 4'b0000, 5'b00000, 1'b0, 3'b000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1, 3'd0};
        vecs[13] = '{16'hFC00, 4'h0, 3'd0, 3'd0, 3'b000, 4'b0000, 5'b00000, 1'b0, 3'b000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1, 3'd4};
        op_pool = '{6'h00, 6'h01, 6'h02, 6'h10, 6'h11, 6'h12, 6'h15, 6'h16, 6'h17, 6'h18, 6'h3F, 6'h08};
        mem[0] = 8'h05;
        mem[1] = 8'h49;

        Reset = 1'b1;
        Flags = 4'h0;
        dec_bus.ir = 16'h0000;
        #2;

        // Directed table: reset, both fetch cycles, then the execute control word and next state.
        for (int i = 0; i < 14; i++) begin
            dec_bus.ir = vecs[i].ir;
            Flags = vecs[i].flags;
            apply_stimulus(1'b1, "vec_reset");
            apply_stimulus(1'b0, "vec_fetch_l");
            apply_stimulus(1'b0, "vec_fetch_h");
            Reset = 1'b0;
            #1;
            check_output($sformatf("vec%0d_exec", i),
                64'({RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel, ALU_WF,
                     ARF_FunSel, ARF_RegSel, MuxASel, MuxBSel, Mem_WR, Mem_CS}),
                64'({vecs[i].rf_outa, vecs[i].rf_outb, vecs[i].rf_fun, vecs[i].rf_reg,
                     vecs[i].alu_fun, vecs[i].alu_wf, vecs[i].arf_fun, vecs[i].arf_reg,
                     vecs[i].mux_a, vecs[i].mux_b, vecs[i].mem_wr, vecs[i].mem_cs}));
            apply_stimulus(1'b0, "vec_exec_full");
            check_output($sformatf("vec%0d_next", i), 64'(State), 64'(vecs[i].next));
        end

        // Halt holds for 20 cycles and only reset releases it.
        for (int i = 0; i < 20; i++) apply_stimulus(1'b0, "halt_idle");
        check_output("halt_flag", 64'(Halted), 64'd1);
        apply_stimulus(1'b1, "halt_reset");
        check_output("halt_release_state", 64'(State), 64'd0);

        // Instruction assembled byte-by-byte from memory, as the datapath would load it.
        dec_bus.ir = 16'h0000;
        apply_stimulus(1'b0, "mem_fetch_l");
        dec_bus.ir = {8'h00, mem[0]};
        apply_stimulus(1'b0, "mem_fetch_h");
        dec_bus.ir = {mem[1], mem[0]};
        #1;
        check_output("mem_imm_regsel", 64'({RF_RegSel, MuxASel}), 64'({4'b0100, 2'b11}));
        apply_stimulus(1'b0, "mem_exec");
        check_output("mem_next_state", 64'(State), 64'd0);

        // Full store: four cycles, second write half uses MuxCSel=1.
        dec_bus.ir = 16'h4700;
        apply_stimulus(1'b0, "str_fetch_l");
        apply_stimulus(1'b0, "str_fetch_h");
        apply_stimulus(1'b0, "str_exec");
        #1;
        check_output("str_exec2", 64'({State, MuxCSel, Mem_WR, Mem_CS, ARF_RegSel}),
                     64'({3'd3, 1'b1, 1'b1, 1'b0, 3'b010}));
        apply_stimulus(1'b0, "str_exec2_full");
        check_output("str_done_state", 64'(State), 64'd0);

        // Reset arriving during the second store cycle kills the write immediately.
        apply_stimulus(1'b0, "str2_fetch_l");
        apply_stimulus(1'b0, "str2_fetch_h");
        apply_stimulus(1'b0, "str2_exec");
        Reset = 1'b1;
        #1;
        check_output("exec2_reset_wr", 64'({State, Mem_WR, Mem_CS}), 64'({3'd3, 1'b0, 1'b1}));
        apply_stimulus(1'b1, "exec2_reset_full");
        check_output("exec2_reset_next", 64'(State), 64'd0);

        // Random instruction stream with random flags and occasional resets.
        for (int c = 0; c < 800; c++) begin
            if (m_step == 0 && !m_halted) begin
                int idx;
                logic [5:0] op;
                idx = $urandom_range(0, 12);
                op = (idx == 12) ? 6'($urandom) : op_pool[idx];
                dec_bus.ir = {op, 10'($urandom)};
            end
            Flags = 4'($urandom);
            apply_stimulus(($urandom_range(0, 39) == 0), "random");
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
